// File: rtl/led_scheduler.sv
// led_scheduler: shares six active-low LEDs between four requesters.
// Round-robin arbitration hands the LEDs out in fixed-length slots. The
// winner's pattern is latched at slot start. The LEDs are blanked when idle.
module led_scheduler #(
  parameter logic [31:0] TICKS_PER_SLOT = 32'd13_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [23:0] pattern,
  output logic [3:0]  grant,
  output logic [5:0]  nLed,
  output logic        busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [1:0]  ptr;
  logic [1:0]  owner;

  logic [1:0]  win;
  logic [5:0]  win_pat;
  logic        slot_end;
  logic        start;

  // Round-robin pick: first requester at or after p, wrapping modulo 4.
  // Scanning offsets from high to low lets the smallest offset win last.
  function automatic logic [1:0] arbitrate(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] sel;
    sel = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) begin
        sel = idx;
      end
    end
    return sel;
  endfunction

  // Winner selection, slot-end detection and the start-new-slot decision.
  always_comb begin
    win = arbitrate(req, ptr);
    case (win)
      2'd0:    win_pat = pattern[5:0];
      2'd1:    win_pat = pattern[11:6];
      2'd2:    win_pat = pattern[17:12];
      2'd3:    win_pat = pattern[23:18];
      default: win_pat = 6'b000000;
    endcase
    if (state == SHOW) begin
      // Timeout and early release merge into one slot end.
      slot_end = (cnt == (TICKS_PER_SLOT - 32'd1)) || !req[owner];
    end else begin
      // When idle the scheduler is always free to start a slot.
      slot_end = 1'b1;
    end
    start = slot_end && (req != 4'b0000);
  end

  // Scheduler FSM: slot start, slot hold and return to idle, with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= 4'b0000;
      nLed  <= 6'b111111;
      busy  <= 1'b0;
      cnt   <= 32'd0;
      ptr   <= 2'd0;
      owner <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHOW;
            owner <= win;
            grant <= 4'b0001 << win;
            nLed  <= ~win_pat;
            busy  <= 1'b1;
            cnt   <= 32'd0;
            ptr   <= win + 2'd1;
          end else begin
            grant <= 4'b0000;
            nLed  <= 6'b111111;
            busy  <= 1'b0;
            cnt   <= 32'd0;
          end
        end
        SHOW: begin
          if (start) begin
            // Back-to-back hand-over: there is no blank cycle between slots.
            owner <= win;
            grant <= 4'b0001 << win;
            nLed  <= ~win_pat;
            busy  <= 1'b1;
            cnt   <= 32'd0;
            ptr   <= win + 2'd1;
          end else if (slot_end) begin
            // Nobody is waiting: blank the LEDs. ptr keeps its position.
            state <= IDLE;
            grant <= 4'b0000;
            nLed  <= 6'b111111;
            busy  <= 1'b0;
            cnt   <= 32'd0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 4'b0000;
          nLed  <= 6'b111111;
          busy  <= 1'b0;
          cnt   <= 32'd0;
        end
      endcase
    end
  end

endmodule
